// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage and the main decoder.
//   fetch_state_t    : fetch FSM states (IDLE -> FETCH -> ISSUE -> FETCH ...)
//   DEFAULT_RESET_PC : default reset vector (word-aligned)
//   OP_J/OP_BEQ/OP_BNE: opcode values of instr[31:26] used by the decoder
//   branch_offset()  : sign-extended, word-scaled branch displacement
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection for the retiring instruction.
//   pc      in  32  address of the retiring instruction
//   instr   in  26  low instruction field (jump index / branch immediate);
//                   the opcode field is decoded upstream into branch/ne/jump
//   branch  in  1   conditional branch
//   ne      in  1   BNE qualifier: taken when zero==0 instead of zero==1
//   zero    in  1   ALU zero flag
//   jump    in  1   unconditional jump, has priority over branch
//   next_pc out 32  address of the next fetch (all adds modulo 2^32)
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr,
  input  logic        branch,
  input  logic        ne,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr, 2'b00};
    end else if (branch && (zero ^ ne)) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches from instruction memory over req/ack and
// hands the word to the decoder/datapath over valid/ready. The next PC is
// chosen from the decoder/ALU outcome in the cycle the instruction retires.
//   clk, reset_n          clock, asynchronous active-low reset
//   imem_req/imem_addr    fetch request (held until ack) and address (= pc)
//   imem_ack/imem_rdata   request completion and instruction word
//   instr/instr_valid     registered instruction awaiting retirement
//   instr_ready           core retires instr this cycle
//   branch/ne/zero/jump   control outcome, sampled only at retirement
//   pc                    address of instr / current fetch
//   retired_cnt           retired-instruction count (wraps)
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch,
  input  logic             ne,
  input  logic             zero,
  input  logic             jump,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired_cnt
);

  fetch_state_t state, state_next;
  logic         capture;
  logic         retire;
  logic [31:0]  next_pc;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          capture    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // imem_req/instr_valid are flops loaded from the next-state decode so they
  // come straight off registers rather than through state-decode logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      imem_req    <= (state_next == FETCH);
      instr_valid <= (state_next == ISSUE);
    end
  end

  next_pc_sel u_next_pc_sel (
    .pc      (pc),
    .instr   (instr[25:0]),
    .branch  (branch),
    .ne      (ne),
    .zero    (zero),
    .jump    (jump),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      retired_cnt <= '0;
    end else begin
      if (capture) begin
        instr <= imem_rdata;
      end
      if (retire) begin
        pc          <= next_pc;
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

  assign imem_addr = pc;

endmodule
